// File: rtl/fpu_pkg.sv
// Shared types and constants for the sequential float add/sub engine.
package fpu_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE
  } state_e;

  localparam logic [1:0] OP_ADD  = 2'b00;  // a + b
  localparam logic [1:0] OP_SUB  = 2'b01;  // a - b
  localparam logic [1:0] OP_RSUB = 2'b10;  // b - a
  localparam logic [1:0] OP_NADD = 2'b11;  // -(a + b)

  localparam int ST_EXACT   = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_UNF     = 2;
  localparam int ST_INEXACT = 3;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
endpackage

// File: rtl/fpu_addsub_seq_if.sv
// Start/done handshake plus operand and result buses of the add/sub engine.
interface fpu_addsub_seq_if #(
  parameter int EXP_W = 7,
  parameter int MAN_W = 24
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] data_out;
  logic [3:0]   status_out;

  modport master (output start, op, a, b, input busy, done, data_out, status_out);
  modport slave  (input start, op, a, b, output busy, done, data_out, status_out);
endinterface

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle float add/sub: bit-serial alignment and normalisation, truncating
// rounding, saturation on overflow and flush-to-zero on underflow.
module fpu_addsub_seq
  import fpu_pkg::*;
#(
  parameter int EXP_W = 7,
  parameter int MAN_W = 24
) (
  input logic             clk,
  input logic             reset,
  fpu_addsub_seq_if.slave io
);
  localparam int W         = 1 + EXP_W + MAN_W;
  localparam int MW        = MAN_W + 1;
  localparam int EW        = EXP_W + $clog2(MAN_W + 2) + 2;
  localparam int CW        = $clog2(MAN_W + 3);
  localparam int MAX_ALIGN = MAN_W + 2;
  localparam logic signed [EW-1:0] EXP_MAX_S = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ONE   = EW'(1);

  state_e                state_q, state_d;
  logic [W-1:0]          a_q, a_d, b_q, b_d;
  logic                  sx_q, sx_d, sub_q, sub_d, sticky_q, sticky_d;
  logic [MW-1:0]         mx_q, mx_d, my_q, my_d;
  logic [MW:0]           sum_q, sum_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [W-1:0]          data_q, data_d;
  logic [3:0]            status_q, status_d;

  logic [EXP_W-1:0] ea, eb, d;
  logic [MW-1:0]    man_a, man_b;
  logic             a_ge_b;
  logic [31:0]      d32;

  // zero operands carry a zero mantissa so the magnitude compare stays correct
  assign ea     = a_q[W-2 -: EXP_W];
  assign eb     = b_q[W-2 -: EXP_W];
  assign man_a  = (ea != '0) ? {1'b1, a_q[MAN_W-1:0]} : '0;
  assign man_b  = (eb != '0) ? {1'b1, b_q[MAN_W-1:0]} : '0;
  assign a_ge_b = {ea, man_a} >= {eb, man_b};
  assign d      = a_ge_b ? (ea - eb) : (eb - ea);
  assign d32    = 32'(d);

  always_comb begin
    logic [1:0]  flip;
    logic [MW:0] sum_n;
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sx_d     = sx_q;
    sub_d    = sub_q;
    sticky_d = sticky_q;
    mx_d     = mx_q;
    my_d     = my_q;
    sum_d    = sum_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    status_d = status_q;
    flip     = 2'b00;
    sum_n    = '0;
    unique case (state_q)
      S_IDLE: if (io.start) begin
        unique case (io.op)
          OP_ADD:  flip = 2'b00;
          OP_SUB:  flip = 2'b01;
          OP_RSUB: flip = 2'b10;
          default: flip = 2'b11;
        endcase
        a_d     = {io.a[W-1] ^ flip[1], io.a[W-2:0]};
        b_d     = {io.b[W-1] ^ flip[0], io.b[W-2:0]};
        state_d = S_UNPACK;
      end
      S_UNPACK: begin
        sx_d     = a_ge_b ? a_q[W-1] : b_q[W-1];
        sub_d    = a_q[W-1] ^ b_q[W-1];
        mx_d     = a_ge_b ? man_a : man_b;
        my_d     = a_ge_b ? man_b : man_a;
        exp_d    = $signed({{(EW-EXP_W){1'b0}}, (a_ge_b ? ea : eb)});
        cnt_d    = (d32 > MAX_ALIGN) ? CW'(MAX_ALIGN) : CW'(d32);
        sticky_d = 1'b0;
        state_d  = S_ALIGN;
      end
      S_ALIGN: begin
        if (cnt_q == '0) state_d = S_ADD;
        else begin
          my_d     = my_q >> 1;
          sticky_d = sticky_q | my_q[0];
          cnt_d    = cnt_q - CW'(1);
        end
      end
      S_ADD: begin
        sum_n = sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});
        sum_d = sum_n;
        if (sum_n == '0)                   state_d = S_PACK;
        else if (sum_n[MW] || !sum_n[MW-1]) state_d = S_NORM;
        else                               state_d = S_PACK;
      end
      S_NORM: begin
        if (sum_q[MW]) begin
          sum_d    = sum_q >> 1;
          sticky_d = sticky_q | sum_q[0];
          exp_d    = exp_q + EXP_ONE;
          state_d  = S_PACK;
        end else begin
          sum_d = sum_q << 1;
          exp_d = exp_q - EXP_ONE;
          if (sum_q[MW-2]) state_d = S_PACK;
        end
      end
      S_PACK: begin
        status_d = '0;
        if (sum_q == '0) begin
          data_d             = '0;
          status_d[ST_EXACT] = 1'b1;
        end else if (exp_q > EXP_MAX_S) begin
          data_d               = {sx_q, {(W-1){1'b1}}};
          status_d[ST_OVF]     = 1'b1;
          status_d[ST_INEXACT] = 1'b1;
        end else if (exp_q < EXP_ONE) begin
          data_d               = '0;
          status_d[ST_UNF]     = 1'b1;
          status_d[ST_INEXACT] = 1'b1;
        end else begin
          data_d               = {sx_q, exp_q[EXP_W-1:0], sum_q[MAN_W-1:0]};
          status_d[ST_INEXACT] = sticky_q;
          status_d[ST_EXACT]   = !sticky_q;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;  // DONE: a start here is deliberately dropped
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sx_q     <= 1'b0;
      sub_q    <= 1'b0;
      sticky_q <= 1'b0;
      mx_q     <= '0;
      my_q     <= '0;
      sum_q    <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sx_q     <= sx_d;
      sub_q    <= sub_d;
      sticky_q <= sticky_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      sum_q    <= sum_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  assign io.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign io.done       = (state_q == S_DONE);
  assign io.data_out   = data_q;
  assign io.status_out = status_q;
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Directed and random checks of fpu_addsub_seq against an arithmetic reference model.
module tb_fpu_addsub_seq;
  import fpu_pkg::*;
  localparam int EXP_W = 7;
  localparam int MAN_W = 24;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int EMAX  = (1 << EXP_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  fpu_addsub_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) io();
  fpu_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (.clk(clk), .reset(reset), .io(io));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] fp(input int s, input int e, input longint m);
    return {1'(s), EXP_W'(e), MAN_W'(m)};
  endfunction

  function automatic int clampe(input int e);
    return (e < 0) ? 0 : ((e > EMAX) ? EMAX : e);
  endfunction

  // Value-level model: align by exponent difference with truncation, add or
  // subtract magnitudes, renormalise, then apply saturation / flush rules.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                                output logic [W-1:0] r, output logic [3:0] st, output int lat);
    int ea, eb, ex, ey, e, steps, p, sx;
    longint ma, mb, mx, my, yint, sum;
    bit sa, sb, sticky;
    sa = a[W-1] ^ op[1];
    sb = b[W-1] ^ op[0];
    ea = int'(a[W-2 -: EXP_W]);
    eb = int'(b[W-2 -: EXP_W]);
    ma = (ea == 0) ? 0 : ((longint'(1) << MAN_W) | longint'(a[MAN_W-1:0]));
    mb = (eb == 0) ? 0 : ((longint'(1) << MAN_W) | longint'(b[MAN_W-1:0]));
    if (ea > eb || (ea == eb && ma >= mb)) begin ex = ea; ey = eb; mx = ma; my = mb; sx = sa; end
    else begin ex = eb; ey = ea; mx = mb; my = ma; sx = sb; end
    steps  = (ex - ey > MAN_W + 2) ? MAN_W + 2 : ex - ey;
    yint   = my >> steps;
    sticky = ((yint << steps) != my);
    sum    = (sa != sb) ? mx - yint : mx + yint;
    lat    = 4 + steps;
    if (sum == 0) begin r = '0; st = 4'b0001; return; end
    p = 0;
    for (int i = 0; i <= MAN_W + 1; i++) if (sum[i]) p = i;
    e = ex;
    if (p > MAN_W) begin sticky |= sum[0]; sum = sum >> 1; e++; lat++; end
    else begin lat += MAN_W - p; sum = sum << (MAN_W - p); e -= MAN_W - p; end
    if (e > EMAX)   begin r = {sx[0], {(W-1){1'b1}}}; st = 4'b1010; end
    else if (e < 1) begin r = '0; st = 4'b1100; end
    else begin r = fp(sx, e, sum); st = sticky ? 4'b1000 : 4'b0001; end
  endfunction

  // One transaction from IDLE; optionally pokes start while busy or during DONE.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input bit poke_busy, input bit poke_done,
                        output logic [W-1:0] r_o, output logic [3:0] st_o, output int lat_o);
    logic [W-1:0] er;
    logic [3:0]   es;
    int           el, lat;
    bit           got;
    model(a, b, op, er, es, el);
    @(negedge clk);
    io.a = a; io.b = b; io.op = op; io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    check({tag, " busy_after_start"}, 64'(io.busy), 64'd1);
    lat = 0; got = 1'b0;
    if (poke_busy) begin
      io.a = ~a; io.b = a; io.op = ~op; io.start = 1'b1;
      @(posedge clk); #1;
      lat++; got = io.done; io.start = 1'b0;
    end
    while (!got && lat < 200) begin
      @(posedge clk); #1;
      lat++; got = io.done;
    end
    check({tag, " done_seen"}, 64'(got), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(el));
    check({tag, " data"}, 64'(io.data_out), 64'(er));
    check({tag, " status"}, 64'(io.status_out), 64'(es));
    check({tag, " flag_rule"}, 64'(io.status_out[0] ^ io.status_out[3]), 64'd1);
    check({tag, " busy_at_done"}, 64'(io.busy), 64'd0);
    r_o = io.data_out; st_o = io.status_out; lat_o = lat;
    if (poke_done) begin
      io.a = ~a; io.b = ~b; io.start = 1'b1;
    end
    @(posedge clk); #1;
    io.start = 1'b0;
    check({tag, " done_pulse"}, 64'(io.done), 64'd0);
    check({tag, " held"}, 64'(io.data_out), 64'(er));
    if (poke_done) check({tag, " start_in_done_ignored"}, 64'(io.busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] r, a, b, one;
    logic [3:0]   st;
    logic [1:0]   op;
    int           lat, ea, eb, mode;
    bit           saw;
    io.start = 1'b0; io.op = 2'b00; io.a = '0; io.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    check("reset busy", 64'(io.busy), 64'd0);
    check("reset done", 64'(io.done), 64'd0);
    check("reset data", 64'(io.data_out), 64'd0);
    check("reset status", 64'(io.status_out), 64'd0);

    one = fp(0, bias(EXP_W), 0);
    run_op("one_plus_one", one, one, 2'b00, 1'b0, 1'b0, r, st, lat);
    check("one_plus_one fixed_data", 64'(r), 64'h40000000);
    check("one_plus_one fixed_status", 64'(st), 64'b0001);
    check("one_plus_one fixed_lat", 64'(lat), 64'd5);
    run_op("one_minus_one", one, one, 2'b01, 1'b0, 1'b0, r, st, lat);
    check("one_minus_one fixed_data", 64'(r), 64'h0);
    check("one_minus_one fixed_status", 64'(st), 64'b0001);
    check("one_minus_one fixed_lat", 64'(lat), 64'd4);
    run_op("overflow", fp(0, 127, 64'hFFFFFF), fp(0, 127, 64'hFFFFFF), 2'b00, 1'b0, 1'b0, r, st, lat);
    check("overflow fixed_data", 64'(r), 64'h7FFFFFFF);
    check("overflow fixed_status", 64'(st), 64'b1010);
    run_op("align24", one, fp(0, 39, 1), 2'b00, 1'b0, 1'b0, r, st, lat);
    check("align24 fixed_status", 64'(st), 64'b1000);
    run_op("underflow", fp(0, 1, 1), fp(0, 1, 0), 2'b01, 1'b0, 1'b0, r, st, lat);
    check("underflow fixed_data", 64'(r), 64'h0);
    check("underflow fixed_status", 64'(st), 64'b1100);
    run_op("rsub", fp(0, 70, 64'h123456), fp(1, 68, 64'h654321), 2'b10, 1'b0, 1'b0, r, st, lat);
    run_op("nadd", fp(0, 64, 64'h800000), fp(0, 90, 64'h000001), 2'b11, 1'b0, 1'b0, r, st, lat);
    run_op("far_align", fp(1, 100, 64'hABCDEF), fp(0, 3, 64'h000001), 2'b00, 1'b0, 1'b0, r, st, lat);

    for (int i = 0; i < 60; i++) begin
      ea   = int'($urandom_range(1, EMAX));
      mode = int'($urandom_range(0, 5));
      case (mode)
        0:       eb = ea;
        1:       eb = clampe(ea + int'($urandom_range(0, 6)) - 3);
        2:       eb = int'($urandom_range(1, EMAX));
        3:       eb = 0;
        default: eb = clampe(ea - 24 - int'($urandom_range(0, 3)));
      endcase
      a  = fp(int'($urandom_range(0, 1)), ea, longint'($urandom));
      b  = (mode == 5) ? a : fp(int'($urandom_range(0, 1)), eb, longint'($urandom));
      op = 2'($urandom_range(0, 3));
      run_op($sformatf("rand%0d", i), a, b, op, 1'b0, 1'b0, r, st, lat);
    end

    // abort mid-ALIGN: a far-apart pair keeps the engine aligning for 26 cycles
    @(negedge clk);
    io.a = fp(0, 100, 64'h00F00F); io.b = fp(0, 10, 64'h0F00F0); io.op = 2'b00; io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("abort busy", 64'(io.busy), 64'd0);
    check("abort done", 64'(io.done), 64'd0);
    check("abort data", 64'(io.data_out), 64'd0);
    check("abort status", 64'(io.status_out), 64'd0);
    @(negedge clk) reset = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (io.done) saw = 1'b1;
    end
    check("abort no_done", 64'(saw), 64'd0);

    run_op("start_while_busy", fp(0, 80, 64'h3C3C3C), fp(1, 60, 64'h5A5A5A), 2'b01, 1'b1, 1'b0, r, st, lat);
    run_op("start_in_done", fp(1, 50, 64'h0F0F0F), fp(1, 49, 64'hF0F0F0), 2'b00, 1'b0, 1'b1, r, st, lat);
    run_op("after_done_poke", one, fp(0, 62, 0), 2'b00, 1'b0, 1'b0, r, st, lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
